mips_muldiv_unit: RTL

//  Iterative multiply/divide unit owning the HI/LO pair, split out of the single-cycle ALU.

---
 rtl/mips_muldiv_unit.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit that owns the HI/LO pair.
// Define MULDIV_MADD_EN to add MADD/MADDU/MSUB/MSUBU, which accumulate into {HI,LO}.
module mips_muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned DW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    localparam logic [3:0] OP_MULT  = 4'b0000;
    localparam logic [3:0] OP_MULTU = 4'b0001;
    localparam logic [3:0] OP_DIV   = 4'b0010;
    localparam logic [3:0] OP_DIVU  = 4'b0011;
    localparam logic [3:0] OP_MTHI  = 4'b0100;
    localparam logic [3:0] OP_MTLO  = 4'b0101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [CW-1:0]    r_cnt;
    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_b_zero;
    logic [WIDTH-1:0] r_hi_acc;
    logic [WIDTH-1:0] r_lo_acc;
    logic [WIDTH-1:0] r_opnd;
`ifdef MULDIV_MADD_EN
    logic             r_acc_en;
    logic             r_acc_sub;
`endif

    logic             w_is_madd;
    logic             w_is_mul;
    logic             w_is_div;
    logic             w_signed;
    logic             w_sign_a;
    logic             w_sign_b;
    logic             w_b_zero;
    logic             w_launch;
    logic [WIDTH-1:0] w_a_abs;
    logic [WIDTH-1:0] w_b_abs;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_sub;
    logic [DW-1:0]    w_prod;
    logic [DW-1:0]    w_prod_fix;
    logic [DW-1:0]    w_mul_res;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;

    // Op decode; bit 0 selects unsigned for every mul/div/accumulate code
`ifdef MULDIV_MADD_EN
    assign w_is_madd = (op[3:2] == 2'b10);
`else
    assign w_is_madd = 1'b0;
`endif
    assign w_is_mul = (op == OP_MULT) | (op == OP_MULTU) | w_is_madd;
    assign w_is_div = (op == OP_DIV) | (op == OP_DIVU);
    assign w_signed = ~op[0];
    assign w_sign_a = w_signed & src_a[WIDTH-1];
    assign w_sign_b = w_signed & src_b[WIDTH-1];
    assign w_b_zero = (src_b == '0);
    assign w_a_abs  = w_sign_a ? -src_a : src_a;
    assign w_b_abs  = w_sign_b ? -src_b : src_b;
    assign w_launch = start & (r_state == S_IDLE) & (w_is_mul | w_is_div);

    // One shift-add multiply step: {carry, hi_acc, lo_acc} >> 1
    assign w_sum = {1'b0, r_hi_acc} + (r_lo_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});

    // One restoring divide step; a zero divisor shifts the dividend into hi_acc unchanged
    assign w_shift   = {r_hi_acc, r_lo_acc[WIDTH-1]};
    assign w_ge      = (w_shift >= {1'b0, r_opnd});
    assign w_rem_sub = w_shift[WIDTH-1:0] - r_opnd;

    // Sign correction of magnitude results
    assign w_prod     = {r_hi_acc, r_lo_acc};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_quo_fix  = r_neg_q ? -r_lo_acc : r_lo_acc;
    assign w_rem_fix  = r_neg_r ? -r_hi_acc : r_hi_acc;

`ifdef MULDIV_MADD_EN
    logic [DW-1:0] w_acc_sum;
    assign w_acc_sum = r_acc_sub ? ({r_hi, r_lo} - w_prod_fix) : ({r_hi, r_lo} + w_prod_fix);
    assign w_mul_res = r_acc_en ? w_acc_sum : w_prod_fix;
`else
    assign w_mul_res = w_prod_fix;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_b_zero <= 1'b0;
            r_hi_acc <= '0;
            r_lo_acc <= '0;
            r_opnd   <= '0;
`ifdef MULDIV_MADD_EN
            r_acc_en  <= 1'b0;
            r_acc_sub <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_state  <= S_RUN;
                        r_busy   <= 1'b1;
                        r_dbz    <= 1'b0;
                        r_cnt    <= '0;
                        r_is_div <= w_is_div;
                        // A zero divisor keeps the all-ones quotient unnegated
                        r_neg_q  <= (w_sign_a ^ w_sign_b) & ~(w_is_div & w_b_zero);
                        r_neg_r  <= w_sign_a;
                        r_b_zero <= w_b_zero;
                        r_hi_acc <= '0;
                        r_lo_acc <= w_a_abs;
                        r_opnd   <= w_b_abs;
`ifdef MULDIV_MADD_EN
                        r_acc_en  <= w_is_madd;
                        r_acc_sub <= op[1];
`endif
                    end else if (start && (op == OP_MTHI)) begin
                        r_hi  <= src_a;
                        r_dbz <= 1'b0;
                    end else if (start && (op == OP_MTLO)) begin
                        r_lo  <= src_a;
                        r_dbz <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (r_is_div) begin
                        r_hi_acc <= w_ge ? w_rem_sub : w_shift[WIDTH-1:0];
                        r_lo_acc <= {r_lo_acc[WIDTH-2:0], w_ge};
                    end else begin
                        r_hi_acc <= w_sum[WIDTH:1];
                        r_lo_acc <= {w_sum[0], r_lo_acc[WIDTH-1:1]};
                    end
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (r_is_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end else begin
                        {r_hi, r_lo} <= w_mul_res;
                    end
                    r_dbz   <= r_is_div & r_b_zero;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule
